// File: rtl/unidade_controle_jogada.sv
// Play-control FSM for a memory game round.
// A round is started by iniciar, each play is taken on a rising edge of
// jogada while waiting in ESPERA, and the round ends on all-correct, a
// wrong play, or a wait that runs past TIMEOUT cycles.
// Moore machine: every output is a decode of the current state.
module unidade_controle_jogada #(
    parameter int TIMEOUT = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       jogada,
    input  logic       igual,
    input  logic       fim,
    output logic       zera,
    output logic       conta,
    output logic       registra,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic       timeout,
    output logic [3:0] db_estado
);

    // The state codes double as the debug encoding.
    localparam logic [3:0] INICIAL     = 4'h0;
    localparam logic [3:0] PREPARA     = 4'h1;
    localparam logic [3:0] ESPERA      = 4'h2;
    localparam logic [3:0] REGISTRA    = 4'h4;
    localparam logic [3:0] COMPARA     = 4'h5;
    localparam logic [3:0] PROXIMO     = 4'h6;
    localparam logic [3:0] FIM_ACERTO  = 4'hA;
    localparam logic [3:0] FIM_ERRO    = 4'hE;
    localparam logic [3:0] FIM_TIMEOUT = 4'hF;

    // Last wait-count value that is still inside the allowed window.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    logic [3:0] state_reg;
    logic [3:0] state_next;
    logic [7:0] wait_cnt_reg;
    logic [7:0] wait_cnt_next;
    logic       jogada_reg;
    logic       jogada_edge;
    logic       wait_expired;

    // A key already held on ESPERA entry has jogada_reg=1, so it never
    // produces an edge; the player must release and press again.
    assign jogada_edge  = jogada & ~jogada_reg;
    assign wait_expired = (wait_cnt_reg == WAIT_LAST);
    assign db_estado    = state_reg;

    // State, wait counter and key history registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg    <= INICIAL;
            wait_cnt_reg <= 8'd0;
            jogada_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            jogada_reg   <= jogada;
        end
    end

    // Wait counter: counts cycles spent in ESPERA, saturates, zero elsewhere.
    always_comb begin
        wait_cnt_next = 8'd0;
        if (state_reg == ESPERA) begin
            if (wait_cnt_reg == 8'hFF) begin
                wait_cnt_next = wait_cnt_reg;
            end else begin
                wait_cnt_next = wait_cnt_reg + 8'd1;
            end
        end
    end

    // Next-state logic; a play edge takes priority over the timeout.
    always_comb begin
        state_next = INICIAL;
        case (state_reg)
            INICIAL:     state_next = iniciar ? PREPARA : INICIAL;
            PREPARA:     state_next = ESPERA;
            ESPERA: begin
                if (jogada_edge) begin
                    state_next = REGISTRA;
                end else if (wait_expired) begin
                    state_next = FIM_TIMEOUT;
                end else begin
                    state_next = ESPERA;
                end
            end
            REGISTRA:    state_next = COMPARA;
            COMPARA: begin
                if (!igual) begin
                    state_next = FIM_ERRO;
                end else if (fim) begin
                    state_next = FIM_ACERTO;
                end else begin
                    state_next = PROXIMO;
                end
            end
            PROXIMO:     state_next = ESPERA;
            FIM_ACERTO:  state_next = iniciar ? PREPARA : FIM_ACERTO;
            FIM_ERRO:    state_next = iniciar ? PREPARA : FIM_ERRO;
            FIM_TIMEOUT: state_next = iniciar ? PREPARA : FIM_TIMEOUT;
            default:     state_next = INICIAL;
        endcase
    end

    // Output decode from the current state only.
    always_comb begin
        zera     = 1'b0;
        conta    = 1'b0;
        registra = 1'b0;
        pronto   = 1'b0;
        acertou  = 1'b0;
        errou    = 1'b0;
        timeout  = 1'b0;
        case (state_reg)
            PREPARA:     zera = 1'b1;
            REGISTRA:    registra = 1'b1;
            PROXIMO:     conta = 1'b1;
            FIM_ACERTO: begin
                pronto  = 1'b1;
                acertou = 1'b1;
            end
            FIM_ERRO: begin
                pronto = 1'b1;
                errou  = 1'b1;
            end
            FIM_TIMEOUT: begin
                pronto  = 1'b1;
                errou   = 1'b1;
                timeout = 1'b1;
            end
            default: begin
                zera = 1'b0;
            end
        endcase
    end

endmodule
